// File: rtl/datapath_pkg.sv
// Shared datapath definitions: op encodings, mul/div FSM states, default width.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package datapath_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Two-bit op field as driven by the control unit.
  // Bit 1 selects divide, and bit 0 selects the unsigned variant.
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } muldivOp_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldivState_e;

  function automatic logic opIsDiv(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic opIsSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the engine: shift-add multiply or restoring divide.
// Latency: combinational, so accOut is valid in the same cycle as accIn.
// Backpressure: none; the caller decides when to register accOut.
//
// Ports:
//   isDiv   - 1 selects the restoring-divide step, and 0 selects the shift-add step.
//   accIn   - {upper WIDTH+1 bits, lower WIDTH bits} accumulator.
//             MUL: upper = partial product, lower = remaining multiplier bits.
//             DIV: upper = partial remainder, lower = dividend bits / quotient bits.
//   operand - multiplicand (MUL) or divisor (DIV), unsigned magnitude.
//   accOut  - accumulator after one iteration.
module muldiv_step
  import datapath_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               isDiv,
  input  logic [2*WIDTH:0]   accIn,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   accOut
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   shRem;

  always_comb begin
    accOut  = accIn;
    sum     = {(WIDTH+1){1'b0}};
    shifted = {(2*WIDTH+1){1'b0}};
    shRem   = {(WIDTH+1){1'b0}};
    if (!isDiv) begin
      // The low bit of the accumulator is the next multiplier bit. The sum stays
      // within WIDTH+1 bits because the upper half is below 2^WIDTH after each shift.
      sum    = accIn[2*WIDTH:WIDTH]
             + (accIn[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      accOut = {sum, accIn[WIDTH-1:0]} >> 1;
    end else begin
      // Bring the next dividend bit into the remainder. The remainder is always
      // below the divisor, so the dropped top bit is zero.
      shifted = accIn << 1;
      shRem   = shifted[2*WIDTH:WIDTH];
      if (shRem >= {1'b0, operand}) begin
        accOut = {shRem - {1'b0, operand}, shifted[WIDTH-1:1], 1'b1};
      end else begin
        accOut = shifted;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine with one bit per cycle, returning a 2*WIDTH-bit result as hi/lo.
// Latency: WIDTH+3 cycles from accepted start to done (2 cycles for divide by zero).
// Backpressure: start is accepted only in IDLE/DONE, and is ignored while busy.
//
// Ports:
//   clock, clear       - rising-edge clock, asynchronous active-low reset.
//   start, op          - request and op code (MUL, MULU, DIV, DIVU), sampled in IDLE/DONE.
//   operand_a/b        - multiplicand/dividend and multiplier/divisor, captured on accept.
//   busy               - high while the engine works (PREP, CALC, FIX).
//   done               - one-cycle pulse when hi/lo/div_by_zero are valid.
//   hi, lo             - MUL: product halves. DIV: remainder / quotient.
//   div_by_zero        - divisor was zero. This output is valid with done and cleared on the next accept.
module muldiv_unit
  import datapath_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  muldivState_e     state;
  muldivState_e     stateNext;

  logic [1:0]       opReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] mReg;       // multiplicand or divisor magnitude used by CALC
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] accStep;
  logic [CW-1:0]    counter;
  logic             signRes;    // result (product/quotient) must be negated
  logic             signRem;    // remainder takes the dividend's sign

  logic             isDivOp;
  logic             isSignedOp;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             divZero;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Operand decode. These values are only consumed in PREP, when aReg/bReg hold the
  // captured request.
  always_comb begin
    isDivOp    = opIsDiv(opReg);
    isSignedOp = opIsSigned(opReg);
    aNeg       = isSignedOp & aReg[WIDTH-1];
    bNeg       = isSignedOp & bReg[WIDTH-1];
    // The most-negative value maps to itself, which is still the correct unsigned magnitude.
    magA       = aNeg ? -aReg : aReg;
    magB       = bNeg ? -bReg : bReg;
    divZero    = isDivOp && (bReg == '0);
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .isDiv   (isDivOp),
    .accIn   (acc),
    .operand (mReg),
    .accOut  (accStep)
  );

  // Sign correction of the finished magnitudes. For most-negative / -1, this gives
  // quotient 2^(WIDTH-1) with no negation, which wraps to the most-negative value.
  always_comb begin
    product   = acc[2*WIDTH-1:0];
    prodFixed = signRes ? -product : product;
    quot      = acc[WIDTH-1:0];
    rem       = acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and status outputs
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = PREP;
      end
      PREP: begin
        busy      = 1'b1;
        stateNext = divZero ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (counter == '0) stateNext = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = start ? PREP : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: capture, iterate, and write results
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      opReg       <= 2'b00;
      aReg        <= '0;
      bReg        <= '0;
      mReg        <= '0;
      acc         <= '0;
      counter     <= '0;
      signRes     <= 1'b0;
      signRem     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            opReg       <= op;
            aReg        <= operand_a;
            bReg        <= operand_b;
            div_by_zero <= 1'b0;
          end
        end
        PREP: begin
          if (divZero) begin
            hi          <= aReg;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            // MUL keeps the multiplier in the low half so its bits shift out.
            // DIV keeps the dividend there so its bits shift into the remainder.
            acc     <= {{(WIDTH+1){1'b0}}, (isDivOp ? magA : magB)};
            mReg    <= isDivOp ? magB : magA;
            signRes <= aNeg ^ bNeg;
            signRem <= aNeg;
            counter <= CW'(WIDTH-1);
          end
        end
        CALC: begin
          acc <= accStep;
          if (counter != '0) counter <= counter - 1'b1;
        end
        FIX: begin
          if (isDivOp) begin
            lo <= signRes ? -quot : quot;
            hi <= signRem ? -rem : rem;
          end else begin
            hi <= prodFixed[2*WIDTH-1:WIDTH];
            lo <= prodFixed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide engine that produces a 2*WIDTH-bit result as HI/LO halves for the datapath's HI and LO registers. It replaces single-cycle 64-bit ALU multiply/divide with an iterative one-bit-per-cycle engine. Width is generalised, and signed and unsigned modes are both supported. A start/busy/done handshake is driven by the control unit, and divide-by-zero is flagged explicitly.

Parameters:
WIDTH, 32, operand width; hi/lo are each WIDTH bits; iteration count equals WIDTH.

Ports:
clock  in  1  system clock, rising edge.
clear  in  1  asynchronous reset, active-low.
start  in  1  request; sampled on a rising edge only in IDLE or DONE.
op  in  2  00 MUL signed, 01 MULU unsigned, 10 DIV signed, 11 DIVU unsigned.
operand_a  in  WIDTH  multiplicand or dividend; captured when start is accepted.
operand_b  in  WIDTH  multiplier or divisor; captured when start is accepted.
busy  out  1  high in PREP, CALC and FIX.
done  out  1  one-cycle pulse while in DONE.
hi  out  WIDTH  MUL: upper product half. DIV: remainder.
lo  out  WIDTH  MUL: lower product half. DIV: quotient.
div_by_zero  out  1  valid with done; cleared on the next accepted start.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; iteration counter=0.
  - Reset mid-operation abandons the operation with no partial result.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE/DONE with start=1:
  - Capture op and operands, clear div_by_zero, go to PREP.
  - A start sampled in DONE is legal, so back-to-back operations are supported.
  - start during PREP/CALC/FIX is ignored and operands are not re-sampled.
- PREP (1 cycle):
  - Signed ops: take magnitudes and record the result sign and remainder sign.
  - Load the accumulator and the counter (counter=WIDTH-1), then go to CALC.
  - DIV/DIVU with operand_b==0: skip CALC and FIX and go straight to DONE with hi=operand_a (as captured), lo=all ones, div_by_zero=1.
- CALC (exactly WIDTH cycles):
  - MUL: shift-add on magnitudes, one multiplier bit per cycle.
  - DIV: restoring division, one quotient bit per cycle.
  - Counter decrements every cycle; leave for FIX when the counter is 0.
- FIX (1 cycle):
  - Apply sign correction and register into hi/lo.
  - Signed MUL: negate the full 2*WIDTH product if the operand signs differ.
  - Signed DIV: quotient truncates toward zero; quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Overflow case, most-negative / -1: lo=most-negative, hi=0 (wraps, no flag).
- DONE (1 cycle): done=1, busy=0; go to PREP if start=1, else IDLE.
- Latency, counting edge 0 as the edge that accepts start:
  - Normal op: done is high after edge WIDTH+2, in cycle WIDTH+3.
  - Divide by zero: done is high after edge 1.
- Result holding:
  - hi/lo hold their value from FIX (or PREP for divide by zero) until the next operation's FIX or divide-by-zero PREP.
  - hi/lo never show intermediate values.
- WIDTH must be ≥ 2. Counter width is clog2(WIDTH).

Decomposition:
- Shared package datapath_pkg holds:
  - 2-bit op encodings (MUL, MULU, DIV, DIVU).
  - The state enum (IDLE, PREP, CALC, FIX, DONE).
  - The default WIDTH constant.
- One natural sub-module: muldiv_step. It is combinational and performs one iteration (shift-add or restore-subtract) on the accumulator, selected by a mul/div flag.
- The FSM, counter, sign handling and output registers stay in muldiv_unit.

Test Plan:
- Reset: clear=0 mid-CALC → busy/done/hi/lo/div_by_zero=0 immediately (asynchronous). Release clear and start MUL 2*3 → lo=6, hi=0.
- MUL signed, WIDTH=32, a=FFFFFFFD (-3), b=00000007 → hi=FFFFFFFF, lo=FFFFFFEB; done high exactly 1 cycle, after edge 34.
- MULU, a=b=FFFFFFFF → hi=FFFFFFFE, lo=00000001. Repeat as MUL signed → hi=0, lo=1.
- DIV signed:
  - a=FFFFFFF9 (-7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF.
  - a=80000000, b=FFFFFFFF → lo=80000000, hi=0, div_by_zero=0.
- DIVU, a=00000064, b=0 → done after edge 1; lo=FFFFFFFF, hi=00000064, div_by_zero=1. Next start clears div_by_zero.
- Back-to-back:
  - Assert start in the DONE cycle with MULU 5*5 → second done after edge 34 of the new op, lo=19h.
  - start pulses during CALC are ignored, and the operand changes they carry do not affect the result.
